// File: rtl/sin_phase_gen.sv
// Phase-accumulator oscillator front end: converts the accumulated phase to an
// IEEE-754 single-precision angle and sequences a downstream sin unit.
module sin_phase_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_req,
    input  logic [31:0] freq_step,
    input  logic [3:0]  prec_in,
    input  logic        sin_done,
    output logic [31:0] theta,
    output logic [3:0]  prec,
    output logic        sin_reset,
    output logic        busy,
    output logic        sample_done,
    output logic        dropped
);

    typedef enum logic [2:0] {IDLE, MUL, NORM, LOAD, RUN} state_t;

    localparam logic [30:0] PI_Q = 31'h6487ED51;

    state_t      state_q, state_d;
    logic [31:0] phase_q, phase_d;
    logic [31:0] samp_q, samp_d;
    logic [3:0]  prec_q, prec_d;
    logic [62:0] prod_q, prod_d;
    logic [5:0]  msb_q, msb_d;
    logic [22:0] mant_q, mant_d;
    logic        nz_q, nz_d;
    logic [31:0] theta_q, theta_d;
    logic        drop_q, drop_d;

    logic [31:0] mag;
    logic [5:0]  lead;
    logic [7:0]  expo;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        samp_d      = samp_q;
        prec_d      = prec_q;
        prod_d      = prod_q;
        msb_d       = msb_q;
        mant_d      = mant_q;
        nz_d        = nz_q;
        theta_d     = theta_q;
        drop_d      = drop_q;
        sample_done = 1'b0;

        // |-2^31| stays 0x80000000, which is correct as an unsigned magnitude
        mag  = samp_q[31] ? (~samp_q + 32'd1) : samp_q;
        expo = {2'b00, msb_q} + 8'd67;

        lead = '0;
        for (int unsigned i = 0; i < 63; i++) begin
            if (prod_q[i]) lead = i[5:0];
        end

        if (sample_req && state_q != IDLE) drop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (sample_req) begin
                    samp_d  = phase_q;
                    prec_d  = prec_in;
                    phase_d = phase_q + freq_step;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d  = {31'b0, mag} * {32'b0, PI_Q};
                state_d = NORM;
            end
            NORM: begin
                msb_d   = lead;
                mant_d  = 23'((prod_q << (6'd62 - lead)) >> 39);
                nz_d    = |prod_q;
                state_d = LOAD;
            end
            LOAD: begin
                theta_d = nz_q ? {samp_q[31], expo, mant_q} : '0;
                state_d = RUN;
            end
            RUN: begin
                if (sin_done) begin
                    sample_done = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            samp_q  <= '0;
            prec_q  <= '0;
            prod_q  <= '0;
            msb_q   <= '0;
            mant_q  <= '0;
            nz_q    <= 1'b0;
            theta_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            samp_q  <= samp_d;
            prec_q  <= prec_d;
            prod_q  <= prod_d;
            msb_q   <= msb_d;
            mant_q  <= mant_d;
            nz_q    <= nz_d;
            theta_q <= theta_d;
            drop_q  <= drop_d;
        end
    end

    assign theta     = theta_q;
    assign prec      = prec_q;
    assign busy      = (state_q != IDLE);
    assign sin_reset = (state_q != RUN);
    assign dropped   = drop_q;

endmodule

// File: tb/tb_sin_phase_gen.sv
// Directed and randomised checks of sin_phase_gen with an expected-result queue.
module tb_sin_phase_gen;

    logic        clk = 1'b0;
    logic        reset, sample_req, sin_done;
    logic [31:0] freq_step;
    logic [3:0]  prec_in;
    logic [31:0] theta;
    logic [3:0]  prec;
    logic        sin_reset, busy, sample_done, dropped;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] phase_m;
    logic [31:0] exp_theta_q[$];
    logic [3:0]  exp_prec_q[$];

    sin_phase_gen dut (
        .clk        (clk),
        .reset      (reset),
        .sample_req (sample_req),
        .freq_step  (freq_step),
        .prec_in    (prec_in),
        .sin_done   (sin_done),
        .theta      (theta),
        .prec       (prec),
        .sin_reset  (sin_reset),
        .busy       (busy),
        .sample_done(sample_done),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_theta(input logic [31:0] ph);
        longint unsigned m, p;
        int              e;
        logic            sg;
        sg = ph[31];
        m  = sg ? (64'h1_0000_0000 - {32'b0, ph}) : {32'b0, ph};
        p  = m * 64'h6487ED51;
        if (p == 0) return 32'h0;
        e = 127;
        while (p >= 64'h2000_0000_0000_0000) begin p = p >> 1; e++; end
        while (p <  64'h1000_0000_0000_0000) begin p = p << 1; e--; end
        return {sg, 8'(e), p[59:37]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_req = 1'b0; sin_done = 1'b0;
        tick();
        reset   = 1'b0;
        phase_m = '0;
        exp_theta_q.delete();
        exp_prec_q.delete();
    endtask

    // dup: 1 = extra request two cycles after accept, 2 = extra request in the done cycle
    task automatic sample(input string tag, input logic [31:0] step, input logic [3:0] p,
                          input int dly, input int dup);
        logic [31:0] et;
        logic [3:0]  ep;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        freq_step = step; prec_in = p; sample_req = 1'b1;
        exp_theta_q.push_back(ref_theta(phase_m));
        exp_prec_q.push_back(p);
        phase_m = phase_m + step;
        tick();                                  // N+1
        sample_req = 1'b0;
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        chk({tag, "_srst1"}, 32'(sin_reset), 32'd1);
        chk({tag, "_sd1"}, 32'(sample_done), 32'd0);
        tick();                                  // N+2
        if (dup == 1) sample_req = 1'b1;
        chk({tag, "_srst2"}, 32'(sin_reset), 32'd1);
        chk({tag, "_sd2"}, 32'(sample_done), 32'd0);
        tick();                                  // N+3
        sample_req = 1'b0;
        if (dup == 1) chk({tag, "_drop"}, 32'(dropped), 32'd1);
        chk({tag, "_srst3"}, 32'(sin_reset), 32'd1);
        chk({tag, "_sd3"}, 32'(sample_done), 32'd0);
        tick();                                  // N+4: RUN
        chk({tag, "_srst4"}, 32'(sin_reset), 32'd0);
        chk({tag, "_busy4"}, 32'(busy), 32'd1);
        if (dly > 0) sin_done = 1'b0;
        for (int i = 0; i < dly; i++) begin
            #1;
            chk({tag, "_sdwait"}, 32'(sample_done), 32'd0);
            tick();
        end
        sin_done = 1'b1;
        if (dup == 2) sample_req = 1'b1;
        #1;
        chk({tag, "_sdone"}, 32'(sample_done), 32'd1);
        et = exp_theta_q.pop_front();
        ep = exp_prec_q.pop_front();
        chk({tag, "_theta"}, theta, et);
        chk({tag, "_prec"}, 32'(prec), 32'(ep));
        tick();
        sin_done = 1'b0; sample_req = 1'b0;
        #1;
        chk({tag, "_sdoff"}, 32'(sample_done), 32'd0);
        chk({tag, "_idle2"}, 32'(busy), 32'd0);
        chk({tag, "_srst5"}, 32'(sin_reset), 32'd1);
        if (dup == 2) chk({tag, "_drop2"}, 32'(dropped), 32'd1);
    endtask

    initial begin
        freq_step = '0; prec_in = '0;
        do_reset();
        chk("rst_theta", theta, 32'h0);
        chk("rst_prec", 32'(prec), 32'd0);
        chk("rst_srst", 32'(sin_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sdone", 32'(sample_done), 32'd0);
        chk("rst_drop", 32'(dropped), 32'd0);

        // quarter-turn stepping around the circle
        sample("q0", 32'h40000000, 4'hA, 3, 0); chk("q0_const", theta, 32'h00000000);
        sample("q1", 32'h40000000, 4'hA, 3, 0); chk("q1_const", theta, 32'h3FC90FDA);
        sample("q2", 32'h40000000, 4'hA, 3, 0); chk("q2_const", theta, 32'hC0490FDA);
        sample("q3", 32'h40000000, 4'hA, 3, 0); chk("q3_const", theta, 32'hBFC90FDA);
        chk("q_prec", 32'(prec), 32'hA);
        chk("q_nodrop", 32'(dropped), 32'd0);

        // request while busy is dropped and does not advance phase
        sample("dup", 32'h40000000, 4'h3, 1, 1); chk("dup_const", theta, 32'h00000000);
        sample("dupn", 32'h40000000, 4'h3, 2, 0); chk("dupn_const", theta, 32'h3FC90FDA);
        chk("dup_sticky", 32'(dropped), 32'd1);

        // reset in the middle of RUN, with a simultaneous request
        do_reset();
        freq_step = 32'h12345678; prec_in = 4'h5; sample_req = 1'b1;
        tick(); sample_req = 1'b0;
        tick(); tick(); tick();
        chk("mid_run", 32'(sin_reset), 32'd0);
        reset = 1'b1; sample_req = 1'b1;
        tick();
        reset = 1'b0; sample_req = 1'b0;
        chk("mid_srst", 32'(sin_reset), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_theta", theta, 32'h0);
        chk("mid_prec", 32'(prec), 32'd0);
        chk("mid_drop", 32'(dropped), 32'd0);
        phase_m = '0;
        sample("after", 32'h40000000, 4'h1, 2, 0); chk("after_const", theta, 32'h00000000);

        // wrap-around of the accumulator
        do_reset();
        sample("w0", 32'h20000000, 4'h7, 1, 0); chk("w0_const", theta, 32'h00000000);
        sample("w1", 32'hF0000000, 4'h7, 1, 0); chk("w1_const", theta, 32'h3F490FDA);
        sample("w2", 32'h00000000, 4'h7, 1, 0); chk("w2_const", theta, 32'h3EC90FDA);
        sample("w3", 32'h00000000, 4'h7, 1, 0); chk("w3_const", theta, 32'h3EC90FDA);

        // request in the done cycle is dropped
        sample("dc", 32'h11111111, 4'h2, 1, 2);
        sample("dcn", 32'h0, 4'h2, 1, 0);

        // sin_done held high while idle must not produce sample_done early
        sin_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_idle", 32'(sample_done), 32'd0);
        end
        sample("hold", 32'h0ABCDEF0, 4'hF, 0, 0);

        for (int k = 0; k < 6; k++) begin
            sample("rnd", $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), 0);
        end
        sample("neg", 32'h9000_0001, 4'h4, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
